stream_output_scheduler: RTL
============================

STREAM_OUTPUT_SCHEDULER -- requirements
Module: stream_output_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of capture channels (1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16777216, WAIT-state watchdog limit in aclk cycles.
REQ-003 SHALL have parameter CNT_BITS, default 16, drop-counter width.
REQ-004 Clock and reset: one clock aclk; reset aresetn, asynchronous, active-low.
REQ-005 Ports SHALL be:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- ch_enable  in  NUM_CH  per-channel enable
- in_done  in  NUM_CH  per-channel capture-done level
- ch_hsize  in  NUM_CH*16  packed widths, ch0 in LSBs
- ch_vsize  in  NUM_CH*16  packed heights, ch0 in LSBs
- time_sec  in  32  timestamp seconds
- time_ns  in  32  timestamp nanoseconds
- rd_start_valid  out  1  read-DMA start request
- rd_start_ready  in  1  read-DMA accepts start
- rd_ch  out  clog2(NUM_CH) (min 1)  granted channel index
- out_done  in  1  packetizer block-done pulse
- out_width  out  16  granted frame width
- out_height  out  16  granted frame height
- out_timestamp  out  64  granted frame {sec,ns}
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle watchdog pulse
- drop_cnt  out  CNT_BITS  saturating overwritten-frame count

Function
REQ-006 in_done edges SHALL be detected per channel with a registered copy (rising edge = in_done & ~in_done_r).
REQ-007 On a rising edge with ch_enable set, the channel SHALL latch its hsize, vsize and {time_sec,time_ns} and set its pending flag in the same cycle.
REQ-008 An edge on an already-pending channel SHALL overwrite its latched metadata (newest wins) and increment drop_cnt, saturating at all-ones.
REQ-009 ch_enable low SHALL clear that channel's pending flag and ignore its edges; latched metadata is retained.
REQ-010 FSM states SHALL be IDLE, STROBE, WAIT.
REQ-011 IDLE: if any pending, SHALL grant one channel by round-robin starting at (last_grant+1) mod NUM_CH, register rd_ch, snapshot that channel's metadata to out_*, and go to STROBE next cycle.
REQ-012 STROBE: rd_start_valid SHALL be 1 and stable with rd_ch until rd_start_ready; on handshake, clear the granted pending flag, update last_grant, go to WAIT.
REQ-013 An edge on the granted channel in the handshake cycle SHALL leave pending set (new frame), update latched metadata only, not increment drop_cnt, and not alter out_*.
REQ-014 WAIT: out_done SHALL return FSM to IDLE; a watchdog counter, cleared on entering WAIT, reaching TIMEOUT_CYCLES-1 SHALL pulse timeout_err for one cycle and return to IDLE.
REQ-015 out_done outside WAIT SHALL be ignored.
REQ-016 Grant latency SHALL be 1 cycle from pending-set in IDLE to rd_start_valid high; minimum IDLE-to-IDLE turnaround is 3 cycles.
REQ-017 Disabling the granted channel during STROBE/WAIT SHALL not abort the transfer.
REQ-018 out_* SHALL hold their values until the next grant.

Reset
REQ-019 On aresetn low: FSM=IDLE, all pending=0, in_done_r=0, last_grant=NUM_CH-1 (first grant ch0), rd_start_valid=0, rd_ch=0, out_width=0, out_height=0, out_timestamp=0, busy=0, timeout_err=0, drop_cnt=0, watchdog=0.
REQ-020 Reset mid-transfer SHALL drop the outstanding grant without emitting timeout_err.

Structure
REQ-021 FSM state encoding and the clog2 helper SHALL reside in the shared stream package.
REQ-022 Round-robin arbiter SHALL be a sub-module rr_arbiter (request vector, pointer, grant index, grant valid), purely combinational.

Verification
REQ-023 NUM_CH=2, ch0 edge, rd_start_ready tied 1 -> rd_start_valid high 1 cycle after pending, rd_ch=0, out_width=ch0 hsize; out_done -> busy=0.
REQ-024 ch0 and ch1 edges same cycle -> grants ch0 then ch1; next simultaneous pair -> ch0 again after ch1 (alternation held).
REQ-025 ch1 two edges while in WAIT on ch0 -> drop_cnt=1, ch1 grant carries second frame's size/timestamp.
REQ-026 TIMEOUT_CYCLES=16, no out_done -> timeout_err single pulse 16 cycles after WAIT entry, FSM IDLE.
REQ-027 rd_start_ready held 0 for 5 cycles -> rd_start_valid/rd_ch stable all 5 cycles; edge on granted channel in handshake cycle -> channel re-pending, drop_cnt unchanged.
REQ-028 aresetn asserted in WAIT -> all outputs at reset values immediately, no timeout_err; CNT_BITS=2 with 5 drops -> drop_cnt=3.

Source files
------------

// File: rtl/stream_output_scheduler_pkg.sv
// Shared definitions for the stream output scheduler: FSM encoding and sizing helper.
package stream_output_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_output_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_vld
);

    // Scan requests circularly starting at ptr, keep the first hit.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_output_scheduler.sv
// Collects per-channel capture-done events, latches frame metadata and hands
// one frame at a time to the read DMA / packetizer via a round-robin grant.
module stream_output_scheduler
    import stream_output_scheduler_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int CNT_BITS       = 16
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_CH-1:0]                   ch_enable,
    input  logic [NUM_CH-1:0]                   in_done,
    input  logic [NUM_CH*16-1:0]                ch_hsize,
    input  logic [NUM_CH*16-1:0]                ch_vsize,
    input  logic [31:0]                         time_sec,
    input  logic [31:0]                         time_ns,
    output logic                                rd_start_valid,
    input  logic                                rd_start_ready,
    output logic [clog2_min1(NUM_CH)-1:0]       rd_ch,
    input  logic                                out_done,
    output logic [15:0]                         out_width,
    output logic [15:0]                         out_height,
    output logic [63:0]                         out_timestamp,
    output logic                                busy,
    output logic                                timeout_err,
    output logic [CNT_BITS-1:0]                 drop_cnt
);

    localparam int CH_W = clog2_min1(NUM_CH);
    localparam int WD_W = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_CH-1:0]             in_done_r_q, pending_q, pending_d, rise;
    logic [NUM_CH-1:0][15:0]       hsize_q, hsize_d, vsize_q, vsize_d;
    logic [NUM_CH-1:0][63:0]       ts_q, ts_d;
    logic [CNT_BITS-1:0]           drop_cnt_q, drop_cnt_d;

    state_e                        state_q, state_d;
    logic [CH_W-1:0]               rd_ch_q, rd_ch_d, last_grant_q, last_grant_d, ptr;
    logic                          rd_start_valid_q, rd_start_valid_d;
    logic                          timeout_err_q, timeout_err_d;
    logic [15:0]                   out_width_q, out_width_d, out_height_q, out_height_d;
    logic [63:0]                   out_ts_q, out_ts_d;
    logic [WD_W-1:0]               wd_q, wd_d;

    logic [CH_W-1:0]               gnt_idx;
    logic                          gnt_vld;
    logic                          handshake;

    assign rise      = in_done & ~in_done_r_q;
    assign handshake = (state_q == ST_STROBE) && rd_start_ready;
    assign ptr       = (last_grant_q == CH_W'(NUM_CH - 1)) ? '0 : last_grant_q + 1'b1;

    rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
        .req     (pending_q),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Per-channel pending/metadata update; a new edge on the channel being
    // handed off in this very cycle is a fresh frame, not an overwrite.
    always_comb begin
        pending_d  = pending_q;
        hsize_d    = hsize_q;
        vsize_d    = vsize_q;
        ts_d       = ts_q;
        drop_cnt_d = drop_cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_enable[i]) begin
                pending_d[i] = 1'b0;
            end else if (rise[i]) begin
                hsize_d[i]   = ch_hsize[i*16 +: 16];
                vsize_d[i]   = ch_vsize[i*16 +: 16];
                ts_d[i]      = {time_sec, time_ns};
                pending_d[i] = 1'b1;
                if (pending_q[i] && !(handshake && rd_ch_q == CH_W'(i)) && drop_cnt_d != '1)
                    drop_cnt_d = drop_cnt_d + 1'b1;
            end else if (handshake && rd_ch_q == CH_W'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Channel-side registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_done_r_q <= '0;
            pending_q   <= '0;
            hsize_q     <= '0;
            vsize_q     <= '0;
            ts_q        <= '0;
            drop_cnt_q  <= '0;
        end else begin
            in_done_r_q <= in_done;
            pending_q   <= pending_d;
            hsize_q     <= hsize_d;
            vsize_q     <= vsize_d;
            ts_q        <= ts_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Grant FSM next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        rd_ch_d          = rd_ch_q;
        last_grant_d     = last_grant_q;
        rd_start_valid_d = 1'b0;
        timeout_err_d    = 1'b0;
        out_width_d      = out_width_q;
        out_height_d     = out_height_q;
        out_ts_d         = out_ts_q;
        wd_d             = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d          = ST_STROBE;
                    rd_ch_d          = gnt_idx;
                    rd_start_valid_d = 1'b1;
                    out_width_d      = hsize_q[gnt_idx];
                    out_height_d     = vsize_q[gnt_idx];
                    out_ts_d         = ts_q[gnt_idx];
                end
            end
            ST_STROBE: begin
                if (rd_start_ready) begin
                    state_d      = ST_WAIT;
                    last_grant_d = rd_ch_q;
                    wd_d         = '0;
                end else begin
                    rd_start_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (out_done) begin
                    state_d = ST_IDLE;
                end else if (wd_q == WD_MAX) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant FSM state and its registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= ST_IDLE;
            rd_ch_q          <= '0;
            last_grant_q     <= CH_W'(NUM_CH - 1);
            rd_start_valid_q <= 1'b0;
            timeout_err_q    <= 1'b0;
            out_width_q      <= '0;
            out_height_q     <= '0;
            out_ts_q         <= '0;
            wd_q             <= '0;
        end else begin
            state_q          <= state_d;
            rd_ch_q          <= rd_ch_d;
            last_grant_q     <= last_grant_d;
            rd_start_valid_q <= rd_start_valid_d;
            timeout_err_q    <= timeout_err_d;
            out_width_q      <= out_width_d;
            out_height_q     <= out_height_d;
            out_ts_q         <= out_ts_d;
            wd_q             <= wd_d;
        end
    end

    assign rd_start_valid = rd_start_valid_q;
    assign rd_ch          = rd_ch_q;
    assign out_width      = out_width_q;
    assign out_height     = out_height_q;
    assign out_timestamp  = out_ts_q;
    assign busy           = (state_q != ST_IDLE);
    assign timeout_err    = timeout_err_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
